mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Three-way memory port arbiter. It issues bursts of up to BURST_MAX beats
//   to one requester at a time. Read/write direction changes insert one TURN
//   cycle.
//   Requesters: 0 = filter load (read), 1 = buffer fill (read),
//   2 = result writeback (write).
//
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous, active-low reset
//     req[2:0]   level requests
//     gnt[2:0]   one-hot grant (GRANT state only)
//     sel[1:0]   granted index, 0 when not granting
//     mem_en     one memory beat per high cycle
//     wr_en      mem_en qualified by owner 2
//     beat       beat index within the current burst
//     burst_done pulse on the last beat of a grant
//     busy       state is not IDLE
//
//   Optional build macro WRITEBACK_PRIORITY_EN: requester 2 wins every
//   arbitration, and requesters 0 and 1 round-robin between themselves.
//   Running bursts are never pre-empted.
module mem_port_arbiter #(
   parameter int unsigned BURST_MAX = 8,
   parameter int unsigned CNT_W     = $clog2(BURST_MAX)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       req,
   output logic [2:0]       gnt,
   output logic [1:0]       sel,
   output logic             mem_en,
   output logic             wr_en,
   output logic [CNT_W-1:0] beat,
   output logic             burst_done,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

   state_t           state_q, state_d;
   logic [1:0]       owner_q, owner_d;
   logic [1:0]       last_owner_q, last_owner_d;
   logic [CNT_W-1:0] beat_q, beat_d;

   logic             in_grant;
   logic             last_beat;
   logic [2:0]       others;
   logic [2:0]       cand;
   logic [1:0]       idle_base;
   logic [1:0]       end_base;
   logic [1:0]       idle_win;
   logic [1:0]       end_win;

   // First requester found scanning base+1, base+2, then base itself.
   function automatic logic [1:0] rr_pick(input logic [2:0] mask, input logic [1:0] base);
      logic [1:0] c1, c2;
      c1 = (base == 2'd2) ? 2'd0 : base + 2'd1;
      c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
      if (mask[c1])      rr_pick = c1;
      else if (mask[c2]) rr_pick = c2;
      else               rr_pick = base;
   endfunction

`ifdef WRITEBACK_PRIORITY_EN
   logic last01_q, last01_d;

   function automatic logic [1:0] arb(input logic [2:0] mask, input logic [1:0] base);
      arb = mask[2] ? 2'd2 : rr_pick(mask & 3'b011, base);
   endfunction

   // Round-robin between 0 and 1 follows its own history. Otherwise every
   // writeback burst would hand the next turn back to requester 0.
   assign idle_base = {1'b0, last01_q};
   assign end_base  = {1'b0, last01_q};
`else
   function automatic logic [1:0] arb(input logic [2:0] mask, input logic [1:0] base);
      arb = rr_pick(mask, base);
   endfunction

   assign idle_base = last_owner_q;
   assign end_base  = owner_q;
`endif

   always_comb begin
      in_grant  = (state_q == GRANT);
      last_beat = in_grant && (!req[owner_q] || (beat_q == CNT_W'(BURST_MAX - 1)));
      // The outgoing owner is excluded unless it is the only one still asking.
      others    = req & ~(3'b001 << owner_q);
      cand      = (others != '0) ? others : req;
      idle_win  = arb(req, idle_base);
      end_win   = arb(cand, end_base);
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      beat_d       = beat_q;
`ifdef WRITEBACK_PRIORITY_EN
      last01_d     = last01_q;
`endif
      unique case (state_q)
         IDLE: begin
            beat_d = '0;
            if (req != '0) begin
               owner_d = idle_win;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (last_beat) begin
               last_owner_d = owner_q;
`ifdef WRITEBACK_PRIORITY_EN
               if (owner_q != 2'd2) last01_d = owner_q[0];
`endif
               beat_d = '0;
               if (cand != '0) begin
                  owner_d = end_win;
                  // Only requester 2 writes, so a direction change means
                  // exactly one side of the handover is owner 2.
                  state_d = ((end_win == 2'd2) != (owner_q == 2'd2)) ? TURN : GRANT;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               beat_d = beat_q + CNT_W'(1);
            end
         end
         TURN: begin
            // The winner is already latched in owner_q, so requests that
            // arrive now cannot change it.
            beat_d  = '0;
            state_d = GRANT;
         end
         default: begin
            beat_d  = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         owner_q      <= 2'd0;
         last_owner_q <= 2'd2;
         beat_q       <= '0;
`ifdef WRITEBACK_PRIORITY_EN
         last01_q     <= 1'b1;
`endif
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         beat_q       <= beat_d;
`ifdef WRITEBACK_PRIORITY_EN
         last01_q     <= last01_d;
`endif
      end
   end

   // A dropped request kills the beat in the same cycle, so mem_en and
   // burst_done look at req directly instead of waiting a cycle.
   always_comb begin
      gnt        = in_grant ? (3'b001 << owner_q) : 3'b000;
      sel        = in_grant ? owner_q : 2'd0;
      mem_en     = in_grant && req[owner_q];
      wr_en      = mem_en && (owner_q == 2'd2);
      beat       = beat_q;
      burst_done = last_beat;
      busy       = (state_q != IDLE);
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned BURST    = 8;
  localparam int unsigned WAIT_MAX = 2 * BURST + 2 + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic       mem_en;
  logic       wr_en;
  logic [2:0] beat;
  logic       burst_done;
  logic       busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.BURST_MAX(BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .mem_en    (mem_en),
    .wr_en     (wr_en),
    .beat      (beat),
    .burst_done(burst_done),
    .busy      (busy)
  );

  typedef struct packed {
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       mem_en;
    logic       wr_en;
    logic [2:0] beat;
    logic       burst_done;
    logic       busy;
  } out_t;

  typedef struct {
    string      name;
    logic       rst;
    logic [2:0] req;
    out_t       exp;
  } vec_t;

  vec_t        vecs[$];
  out_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned wait_cnt[3];
  logic        prev_rst_low;

  task automatic add(input string nm, input logic r, input logic [2:0] rq, input int own,
                     input logic me, input int bt, input logic bd, input logic bz);
    vec_t v;
    v.name           = nm;
    v.rst            = r;
    v.req            = rq;
    v.exp.gnt        = (own < 0) ? 3'b000 : 3'(1 << own);
    v.exp.sel        = (own < 0) ? 2'd0 : 2'(own);
    v.exp.mem_en     = me;
    v.exp.wr_en      = me && (own == 2);
    v.exp.beat       = 3'(bt);
    v.exp.burst_done = bd;
    v.exp.busy       = bz;
    vecs.push_back(v);
  endtask

  task automatic idle(input string nm, input logic r, input logic [2:0] rq);
    add(nm, r, rq, -1, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic turn(input string nm, input logic [2:0] rq);
    add(nm, 1'b1, rq, -1, 1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic burst(input string nm, input logic [2:0] rq, input int own, input int n);
    for (int b = 0; b < n; b++)
      add(nm, 1'b1, rq, own, 1'b1, b, (b == 7), 1'b1);
  endtask

  task automatic build_table;
    idle ("reset",      1'b0, 3'b000);
    idle ("a_idle",     1'b1, 3'b001);
    burst("a_burst0",   3'b001, 0, 8);
    burst("a_regrant",  3'b001, 0, 4);
    add  ("a_release",  1'b1, 3'b000, 0, 1'b0, 4, 1'b1, 1'b1);
    idle ("a_back_idle",1'b1, 3'b000);

    idle ("b_reset",    1'b0, 3'b000);
    idle ("b_idle",     1'b1, 3'b011);
    burst("b_own0",     3'b011, 0, 8);
    burst("b_own1",     3'b011, 1, 8);
    burst("b_own0b",    3'b011, 0, 8);
    add  ("b_release",  1'b1, 3'b000, 1, 1'b0, 0, 1'b1, 1'b1);
    idle ("b_back_idle",1'b1, 3'b000);

    idle ("d_reset",    1'b0, 3'b000);
    idle ("d_idle",     1'b1, 3'b010);
    burst("d_own1",     3'b010, 1, 3);
    add  ("d_drop",     1'b1, 3'b000, 1, 1'b0, 3, 1'b1, 1'b1);
    idle ("d_back_idle",1'b1, 3'b000);

`ifndef WRITEBACK_PRIORITY_EN
    idle ("c_reset",    1'b0, 3'b000);
    idle ("c_idle",     1'b1, 3'b101);
    burst("c_own0",     3'b101, 0, 8);
    turn ("c_turn_rw",  3'b111);
    burst("c_own2",     3'b101, 2, 8);
    turn ("c_turn_wr",  3'b000);
    add  ("c_release",  1'b1, 3'b000, 0, 1'b0, 0, 1'b1, 1'b1);
    idle ("c_back_idle",1'b1, 3'b000);

    idle ("e_reset",    1'b0, 3'b000);
    idle ("e_idle",     1'b1, 3'b100);
    burst("e_own2",     3'b100, 2, 4);
    add  ("e_rst_beat4",1'b0, 3'b100, 2, 1'b1, 4, 1'b0, 1'b1);
    idle ("e_after_rst",1'b1, 3'b111);
    add  ("e_first0",   1'b1, 3'b111, 0, 1'b1, 0, 1'b0, 1'b1);
    add  ("e_release",  1'b1, 3'b000, 0, 1'b0, 1, 1'b1, 1'b1);
    idle ("e_back_idle",1'b1, 3'b000);
`else
    idle ("p_reset",    1'b0, 3'b000);
    idle ("p_idle",     1'b1, 3'b111);
    burst("p_own2a",    3'b111, 2, 8);
    turn ("p_turn1",    3'b111);
    burst("p_own0",     3'b111, 0, 8);
    turn ("p_turn2",    3'b111);
    burst("p_own2b",    3'b111, 2, 8);
    turn ("p_turn3",    3'b111);
    burst("p_own1",     3'b111, 1, 8);
    turn ("p_turn4",    3'b000);
    add  ("p_release",  1'b1, 3'b000, 2, 1'b0, 0, 1'b1, 1'b1);
    idle ("p_back_idle",1'b1, 3'b000);
`endif
  endtask

  initial begin
    out_t got;
    out_t exp;
    rst = 1'b0;
    req = 3'b000;
    prev_rst_low = 1'b1;
    for (int unsigned k = 0; k < 3; k++) wait_cnt[k] = 0;
    build_table();
    repeat (2) @(posedge clk);

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst;
      req = vecs[i].req;
      sb.push_back(vecs[i].exp);
      @(negedge clk);
      got = '{gnt: gnt, sel: sel, mem_en: mem_en, wr_en: wr_en,
              beat: beat, burst_done: burst_done, busy: busy};
      exp = sb.pop_front();
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s row %0d: got gnt=%b sel=%0d mem_en=%b wr_en=%b beat=%0d done=%b busy=%b; want gnt=%b sel=%0d mem_en=%b wr_en=%b beat=%0d done=%b busy=%b",
                 vecs[i].name, i, got.gnt, got.sel, got.mem_en, got.wr_en, got.beat,
                 got.burst_done, got.busy, exp.gnt, exp.sel, exp.mem_en, exp.wr_en,
                 exp.beat, exp.burst_done, exp.busy);
      end

      if (prev_rst_low && (got !== '0)) begin
        n_err++;
        $display("FAIL %s row %0d: outputs not cleared by reset, got gnt=%b sel=%0d mem_en=%b wr_en=%b beat=%0d done=%b busy=%b",
                 vecs[i].name, i, got.gnt, got.sel, got.mem_en, got.wr_en, got.beat,
                 got.burst_done, got.busy);
      end
      prev_rst_low = !vecs[i].rst;

`ifndef WRITEBACK_PRIORITY_EN
      for (int unsigned k = 0; k < 3; k++) begin
        if (!vecs[i].rst || !req[k] || gnt[k]) wait_cnt[k] = 0;
        else wait_cnt[k]++;
        if (wait_cnt[k] > WAIT_MAX) begin
          n_err++;
          $display("FAIL %s row %0d: requester %0d waited %0d cycles, limit %0d",
                   vecs[i].name, i, k, wait_cnt[k], WAIT_MAX);
        end
      end
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
